// File: rtl/axi_read_responder.sv
// AXI4 read-channel responder serving in-order bursts from a backdoor-filled word array.
// Optional AXI_RD_DECERR_EN: out-of-window beats return DECERR instead of wrapping the index.
module axi_read_responder #(
    parameter int                    ID_WIDTH   = 13,
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ID_WIDTH-1:0]          s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic [2:0]                   s_axi_arsize,
    input  logic [1:0]                   s_axi_arburst,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [ID_WIDTH-1:0]          s_axi_rid,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_WORDS)-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic                         busy
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [7:0]              beat_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic                    slv_q;
    logic                    ar_fire;
    logic                    r_fire;
    logic [ADDR_WIDTH-1:0]   beat_addr;
    logic                    slv_sel;
    logic [1:0]              resp_sel;
    logic [DATA_WIDTH-1:0]   data_sel;

    function automatic logic is_slverr(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > 3'd3) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst,
                                                        input logic [7:0] len);
        logic [ADDR_WIDTH-1:0] bytes;
        logic [ADDR_WIDTH-1:0] boundary;
        logic [ADDR_WIDTH-1:0] res;
        bytes    = ADDR_WIDTH'(1) << size;
        boundary = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * bytes;
        case (burst)
            2'b01:   res = (addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
            2'b10:   res = (addr & ~(boundary - ADDR_WIDTH'(1)))
                         | ((addr + bytes) & (boundary - ADDR_WIDTH'(1)));
            default: res = addr;
        endcase
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - MEM_BASE) >> 3);
    endfunction

`ifdef AXI_RD_DECERR_EN
    localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = MEM_BASE + ADDR_WIDTH'(MEM_WORDS * 8);

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr < MEM_BASE) || (addr >= MEM_LIMIT);
    endfunction
`endif

    always_comb begin
        state_next = state;
        ar_fire    = 1'b0;
        r_fire     = 1'b0;
        case (state)
            IDLE: begin
                if (s_axi_arvalid && s_axi_arready) begin
                    ar_fire    = 1'b1;
                    state_next = BURST;
                end
            end
            BURST: begin
                if (s_axi_rvalid && s_axi_rready) begin
                    r_fire = 1'b1;
                    if (s_axi_rlast) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat lookup: the AR address for beat 0, otherwise the successor of the held beat.
    always_comb begin
        if (state == IDLE) begin
            beat_addr = s_axi_araddr;
            slv_sel   = is_slverr(s_axi_arsize, s_axi_arburst, s_axi_arlen);
        end else begin
            beat_addr = next_addr(addr_q, size_q, burst_q, len_q);
            slv_sel   = slv_q;
        end
        resp_sel = 2'b00;
        data_sel = mem[word_index(beat_addr)];
        if (slv_sel) begin
            resp_sel = 2'b10;
            data_sel = '0;
        end
`ifdef AXI_RD_DECERR_EN
        else if (out_of_range(beat_addr)) begin
            resp_sel = 2'b11;
            data_sel = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Burst context registers carry no reset; they are reloaded on every AR handshake.
    always_ff @(posedge clk) begin
        if (ar_fire) begin
            addr_q  <= s_axi_araddr;
            len_q   <= s_axi_arlen;
            size_q  <= s_axi_arsize;
            burst_q <= s_axi_arburst;
            slv_q   <= slv_sel;
            beat_q  <= 8'd0;
        end else if (r_fire && !s_axi_rlast) begin
            addr_q  <= beat_addr;
            beat_q  <= beat_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rresp   <= 2'b00;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
        end else begin
            s_axi_arready <= (state_next == IDLE);
            if (ar_fire) begin
                s_axi_rid    <= s_axi_arid;
                s_axi_rvalid <= 1'b1;
                s_axi_rlast  <= (s_axi_arlen == 8'd0);
                s_axi_rresp  <= resp_sel;
                s_axi_rdata  <= data_sel;
            end else if (r_fire) begin
                if (s_axi_rlast) begin
                    s_axi_rvalid <= 1'b0;
                    s_axi_rlast  <= 1'b0;
                end else begin
                    s_axi_rlast  <= ((beat_q + 8'd1) == len_q);
                    s_axi_rresp  <= resp_sel;
                    s_axi_rdata  <= data_sel;
                end
            end
        end
    end

    assign busy = (state == BURST);

endmodule

// File: tb/tb_axi_read_responder.sv
// Bench for axi_read_responder: table of bursts checked through a beat scoreboard, plus hand sequences.
module tb_axi_read_responder;

    localparam int IDW = 13;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int MW  = 1024;
    localparam int IXW = 10;
    localparam int NV  = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [IDW-1:0]  s_axi_arid = '0;
    logic [AW-1:0]   s_axi_araddr = '0;
    logic [7:0]      s_axi_arlen = '0;
    logic [2:0]      s_axi_arsize = '0;
    logic [1:0]      s_axi_arburst = '0;
    logic            s_axi_arvalid = 1'b0;
    logic            s_axi_arready;
    logic [IDW-1:0]  s_axi_rid;
    logic [DW-1:0]   s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rlast;
    logic            s_axi_rvalid;
    logic            s_axi_rready = 1'b0;
    logic            mem_we = 1'b0;
    logic [IXW-1:0]  mem_waddr = '0;
    logic [DW-1:0]   mem_wdata = '0;
    logic            busy;

    always #5 clk = ~clk;

    axi_read_responder dut (
        .clk(clk), .reset(reset),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        logic [2:0]     size;
        logic [1:0]     burst;
        bit             stall;
    } vec_t;

    typedef struct {
        logic [DW-1:0]  data;
        logic [1:0]     resp;
        logic           last;
        logic [IDW-1:0] id;
    } beat_t;

    vec_t  vec [NV];
    int    exp_word [NV][8];   // >=0: OKAY word index, -2: SLVERR, -3: DECERR
    beat_t sb [$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue_ar(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, output bit ok);
        int c = 0;
        @(negedge clk);
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arsize  = size;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        while (!s_axi_arready && c < 20) begin
            @(negedge clk);
            c++;
        end
        ok = s_axi_arready;
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        check("arready wait", 64'(ok), 64'd1);
    endtask

    task automatic run_burst(input int v);
        beat_t         e;
        bit            ok;
        bit            hold = 1'b0;
        logic [DW-1:0] pdata = '0;
        logic          plast = 1'b0;
        int            c = 0;
        int            k = 0;
        for (int b = 0; b <= int'(vec[v].len); b++) begin
            int w;
            w      = exp_word[v][b];
            e.id   = vec[v].id;
            e.last = (b == int'(vec[v].len));
            e.resp = (w >= 0) ? 2'b00 : ((w == -2) ? 2'b10 : 2'b11);
            e.data = (w >= 0) ? 64'hA000 + 64'(w) : 64'h0;
            sb.push_back(e);
        end
        issue_ar(vec[v].id, vec[v].addr, vec[v].len, vec[v].size, vec[v].burst, ok);
        check($sformatf("v%0d first rvalid", v), 64'(s_axi_rvalid), 64'd1);
        check($sformatf("v%0d busy", v), 64'(busy), 64'd1);
        check($sformatf("v%0d arready low", v), 64'(s_axi_arready), 64'd0);
        while (sb.size() > 0 && c < 200) begin
            if (hold) begin
                check($sformatf("v%0d stall rdata", v), s_axi_rdata, pdata);
                check($sformatf("v%0d stall rlast", v), 64'(s_axi_rlast), 64'(plast));
            end
            s_axi_rready = vec[v].stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            if (s_axi_rvalid && s_axi_rready) begin
                e = sb.pop_front();
                check($sformatf("v%0d b%0d rdata", v, k), s_axi_rdata, e.data);
                check($sformatf("v%0d b%0d rresp", v, k), 64'(s_axi_rresp), 64'(e.resp));
                check($sformatf("v%0d b%0d rlast", v, k), 64'(s_axi_rlast), 64'(e.last));
                check($sformatf("v%0d b%0d rid", v, k), 64'(s_axi_rid), 64'(e.id));
                k++;
                hold = 1'b0;
            end else begin
                hold  = s_axi_rvalid;
                pdata = s_axi_rdata;
                plast = s_axi_rlast;
            end
            @(negedge clk);
            c++;
        end
        if (sb.size() > 0) begin
            check($sformatf("v%0d beats left", v), 64'(sb.size()), 64'd0);
            sb.delete();
        end
        s_axi_rready = 1'b0;
        check($sformatf("v%0d rvalid after", v), 64'(s_axi_rvalid), 64'd0);
        check($sformatf("v%0d arready after", v), 64'(s_axi_arready), 64'd1);
        check($sformatf("v%0d busy after", v), 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        vec[0] = '{13'h5,    64'h40,   8'd7, 3'd3, 2'b01, 1'b0};
        vec[1] = '{13'h5,    64'h40,   8'd7, 3'd3, 2'b01, 1'b1};
        vec[2] = '{13'h1A5,  64'h18,   8'd3, 3'd3, 2'b10, 1'b0};
        vec[3] = '{13'h1,    64'h10,   8'd2, 3'd3, 2'b00, 1'b0};
        vec[4] = '{13'h2,    64'h10,   8'd2, 3'd4, 2'b01, 1'b0};
        vec[5] = '{13'h3,    64'h20,   8'd2, 3'd3, 2'b10, 1'b0};
        vec[6] = '{13'h4,    64'h20,   8'd1, 3'd3, 2'b11, 1'b0};
        vec[7] = '{13'h1FFF, 64'h44,   8'd3, 3'd2, 2'b01, 1'b0};
        vec[8] = '{13'h6,    64'h70,   8'd7, 3'd3, 2'b10, 1'b1};
        vec[9] = '{13'h9,    64'h1FF8, 8'd1, 3'd3, 2'b01, 1'b0};
        exp_word[0] = '{8, 9, 10, 11, 12, 13, 14, 15};
        exp_word[1] = '{8, 9, 10, 11, 12, 13, 14, 15};
        exp_word[2] = '{3, 0, 1, 2, 0, 0, 0, 0};
        exp_word[3] = '{2, 2, 2, 0, 0, 0, 0, 0};
        exp_word[4] = '{-2, -2, -2, 0, 0, 0, 0, 0};
        exp_word[5] = '{-2, -2, -2, 0, 0, 0, 0, 0};
        exp_word[6] = '{-2, -2, 0, 0, 0, 0, 0, 0};
        exp_word[7] = '{8, 9, 9, 10, 0, 0, 0, 0};
        exp_word[8] = '{14, 15, 8, 9, 10, 11, 12, 13};
`ifdef AXI_RD_DECERR_EN
        exp_word[9] = '{1023, -3, 0, 0, 0, 0, 0, 0};
`else
        exp_word[9] = '{1023, 0, 0, 0, 0, 0, 0, 0};
`endif

        // Preload while reset is held; the array is not affected by reset.
        for (int i = 0; i < MW; i++) begin
            @(negedge clk);
            mem_we    = 1'b1;
            mem_waddr = IXW'(i);
            mem_wdata = 64'hA000 + 64'(i);
        end
        @(negedge clk);
        mem_we = 1'b0;

        check("rst arready", 64'(s_axi_arready), 64'd0);
        check("rst rvalid", 64'(s_axi_rvalid), 64'd0);
        check("rst rlast", 64'(s_axi_rlast), 64'd0);
        check("rst rresp", 64'(s_axi_rresp), 64'd0);
        check("rst rid", 64'(s_axi_rid), 64'd0);
        check("rst rdata", s_axi_rdata, 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        reset = 1'b1;
        check("arready before edge", 64'(s_axi_arready), 64'd0);
        @(negedge clk);
        check("arready after release", 64'(s_axi_arready), 64'd1);

        for (int v = 0; v < NV; v++) run_burst(v);

        // Reset while beat 3 of an 8-beat INCR is presented.
        issue_ar(13'h5, 64'h40, 8'd7, 3'd3, 2'b01, ok);
        s_axi_rready = 1'b1;
        check("rst seq beat0", s_axi_rdata, 64'hA008);
        @(negedge clk);
        check("rst seq beat1", s_axi_rdata, 64'hA009);
        @(negedge clk);
        check("rst seq beat2", s_axi_rdata, 64'hA00A);
        reset = 1'b0;
        s_axi_rready = 1'b0;
        @(negedge clk);
        check("mid rst rvalid", 64'(s_axi_rvalid), 64'd0);
        check("mid rst arready", 64'(s_axi_arready), 64'd0);
        check("mid rst busy", 64'(busy), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post rst arready", 64'(s_axi_arready), 64'd1);
        run_burst(0);

        // Backdoor write to the word being presented during a stall.
        issue_ar(13'h7, 64'h10, 8'd2, 3'd3, 2'b00, ok);
        check("bd beat0", s_axi_rdata, 64'hA002);
        mem_we    = 1'b1;
        mem_waddr = IXW'(2);
        mem_wdata = 64'hBEEF;
        @(negedge clk);
        mem_we = 1'b0;
        check("bd held", s_axi_rdata, 64'hA002);
        s_axi_rready = 1'b1;
        @(negedge clk);
        check("bd beat1", s_axi_rdata, 64'hBEEF);
        check("bd beat1 rlast", 64'(s_axi_rlast), 64'd0);
        @(negedge clk);
        check("bd beat2", s_axi_rdata, 64'hBEEF);
        check("bd beat2 rlast", 64'(s_axi_rlast), 64'd1);
        @(negedge clk);
        check("bd rvalid after", 64'(s_axi_rvalid), 64'd0);
        s_axi_rready = 1'b0;
        mem_we    = 1'b1;
        mem_wdata = 64'hA002;
        @(negedge clk);
        mem_we = 1'b0;
        run_burst(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_read_responder.md
Name: axi_read_responder

Overview:
AXI4 read-channel slave (AR/R) that serves burst reads from an internal word-addressed memory array. It is the responder counterpart of the CPU instruction-fetch read master and is used as the fetch-side memory model in simulation and as on-chip boot ROM/RAM. A backdoor write port fills the array. The block handles one outstanding burst at a time, in order.

Parameters:
ID_WIDTH, 13, width of arid/rid.
ADDR_WIDTH, 64, address width.
DATA_WIDTH, 64, R data width; must be 64 (8-byte lanes).
MEM_WORDS, 1024, array depth in DATA_WIDTH words; power of two.
MEM_BASE, 64'h0, byte address of word 0; 8-byte aligned.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
s_axi_arid  in  ID_WIDTH  burst ID
s_axi_araddr  in  ADDR_WIDTH  start byte address
s_axi_arlen  in  8  beats minus 1
s_axi_arsize  in  3  log2 bytes per beat
s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  ID_WIDTH  echoed arid
s_axi_rdata  out  DATA_WIDTH  beat data
s_axi_rresp  out  2  response
s_axi_rlast  out  1  final beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
mem_we  in  1  backdoor write enable
mem_waddr  in  $clog2(MEM_WORDS)  backdoor word index
mem_wdata  in  DATA_WIDTH  backdoor data
busy  out  1  burst in progress (state != IDLE)

Behaviour:
- Reset (reset==0 at posedge clk): state IDLE; arready=0, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, busy=0. Memory contents are not cleared. Reset mid-burst abandons the burst with no further beats.
- States: IDLE, BURST.
- IDLE: arready=1 (registered; goes high the first cycle after reset deasserts). On arvalid&&arready, capture id/addr/len/size/burst, clear beat counter, and register beat 0 data. Next cycle: BURST, arready=0, rvalid=1. AR-handshake-to-first-rvalid latency is exactly 1 cycle.
- BURST: rid/rdata/rresp/rlast stay stable while rvalid&&!rready. On rvalid&&rready: if rlast, go to IDLE (rvalid=0, arready=1 the next cycle; no AR is accepted in the same cycle as the last R handshake). Otherwise compute the next address, register next beat data, and keep rvalid=1, giving back-to-back beats with rready held high.
- rlast=1 exactly when beat counter == captured len; counter is 8 bits, so len=255 gives 256 beats.
- Address update, with bytes = 1<<size:
  - FIXED: unchanged.
  - INCR: aligned_addr + bytes, where aligned_addr = addr & ~(bytes-1).
  - WRAP: boundary = (len+1)*bytes; next = (addr & ~(boundary-1)) | ((addr + bytes) & (boundary-1)).
- Word index = (addr - MEM_BASE) >> 3. The full 64-bit word is returned regardless of size; the master selects lanes.
- Burst SLVERR (rresp=2'b10, rdata=0, every beat, rlast still correct): size > 3; burst==2'b11; WRAP with len not in {1,3,7,15}.
- Backdoor write: mem_we writes the array at posedge. A write to the word of the currently presented beat does not change the held rdata; later beats see the new data.

Optional Feature:
AXI_RD_DECERR_EN:
- Defined: a beat whose address is < MEM_BASE or >= MEM_BASE+MEM_WORDS*8 returns rresp=2'b11 (DECERR) and rdata=0. The check is per beat; the burst continues and the other beats are unaffected.
- Undefined: the word index is truncated modulo MEM_WORDS, and rresp=OKAY.
- SLVERR takes priority over DECERR.

Test Plan:
1. Preload word[i]=64'hA000+i. AR INCR addr=0x40, len=7, size=3, id=0x5, rready=1 -> rvalid 1 cycle after handshake; 8 consecutive beats with data 0xA008..0xA00F, rid=0x5, rresp=0, rlast only on beat 8; arready=1 the cycle after.
2. Same burst with rready toggled 1,0,0,1 -> rdata/rlast stable during stalls; each word delivered exactly once, in order.
3. WRAP addr=0x18, len=3, size=3 -> data word[3], word[0], word[1], word[2]; rlast on the 4th beat.
4. FIXED addr=0x10, len=2 -> three beats of 0xA002. Then INCR with size=4 -> three beats rresp=2'b10, rdata=0.
5. Reset low on beat 3 of an 8-beat INCR -> next cycle rvalid=0 and arready=0. After release, arready=1 and a new AR is served from beat 0.
6. With AXI_RD_DECERR_EN, MEM_WORDS=1024: INCR addr=0x1FF8, len=1 -> beat 1 word[1023] OKAY, beat 2 rresp=2'b11, rdata=0, rlast=1. Without the macro -> beat 2 returns word[0] with OKAY.
